alu_seq: RTL and testbench



---
 rtl/alu_seq.sv | 197 +++++++++++++++++++
 tb/tb_alu_seq.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU sequencer.
// Accepts one instruction plus operands, decodes it into ALU control/operands,
// drives an external combinational ALU from registers, captures its result and
// hands a write-back record to the register file over a valid/ready handshake.
module alu_seq (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_aluc,
  input  logic [31:0] alu_s,
  input  logic        alu_z,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_z,
  output logic [4:0]  out_rd,
  output logic        out_wreg,
  output logic        out_illegal,
  output logic [31:0] op_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Latched request
  logic [31:0] instr_q, rs_q, rt_q;

  // Registered ALU drive and write-back record
  logic [31:0] alu_a_q, alu_b_q;
  logic [3:0]  aluc_q;
  logic [31:0] result_q;
  logic        z_q;
  logic [4:0]  rd_q;
  logic        wreg_q;
  logic        illegal_q;
  logic [31:0] op_count_q;

  // Decoder outputs
  logic [31:0] dec_a, dec_b;
  logic [3:0]  dec_aluc;
  logic [4:0]  dec_rd;
  logic        dec_illegal;

  logic [5:0]  opcode, funct;
  logic [15:0] imm;

  assign opcode = instr_q[31:26];
  assign funct  = instr_q[5:0];
  assign imm    = instr_q[15:0];

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = DECODE;
      end
      DECODE: state_d = EXEC;
      EXEC:   state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Instruction decode: anything not matched stays illegal with zeroed operands
  always_comb begin
    dec_a       = 32'd0;
    dec_b       = 32'd0;
    dec_aluc    = 4'b0000;
    dec_rd      = 5'd0;
    dec_illegal = 1'b1;
    case (opcode)
      6'b000000: begin
        case (funct)
          6'b100000, 6'b100001: begin dec_aluc = 4'b0000; dec_illegal = 1'b0; end
          6'b100010, 6'b100011: begin dec_aluc = 4'b0100; dec_illegal = 1'b0; end
          6'b100100:            begin dec_aluc = 4'b0001; dec_illegal = 1'b0; end
          6'b100101:            begin dec_aluc = 4'b0101; dec_illegal = 1'b0; end
          6'b100110:            begin dec_aluc = 4'b0010; dec_illegal = 1'b0; end
          6'b101000:            begin dec_aluc = 4'b1011; dec_illegal = 1'b0; end
          6'b000000:            begin dec_aluc = 4'b0011; dec_illegal = 1'b0; end
          6'b000010:            begin dec_aluc = 4'b0111; dec_illegal = 1'b0; end
          6'b000011:            begin dec_aluc = 4'b1111; dec_illegal = 1'b0; end
          default: ;
        endcase
        if (!dec_illegal) begin
          dec_rd = instr_q[15:11];
          dec_b  = rt_q;
          // Shifts take the amount from the sa field instead of rs
          if (funct[5] == 1'b0) dec_a = {27'd0, instr_q[10:6]};
          else                  dec_a = rs_q;
        end
      end
      6'b001000: begin
        dec_aluc = 4'b0000; dec_illegal = 1'b0;
        dec_a = rs_q; dec_b = {{16{imm[15]}}, imm}; dec_rd = instr_q[20:16];
      end
      6'b001100: begin
        dec_aluc = 4'b0001; dec_illegal = 1'b0;
        dec_a = rs_q; dec_b = {16'd0, imm}; dec_rd = instr_q[20:16];
      end
      6'b001101: begin
        dec_aluc = 4'b0101; dec_illegal = 1'b0;
        dec_a = rs_q; dec_b = {16'd0, imm}; dec_rd = instr_q[20:16];
      end
      6'b001110: begin
        dec_aluc = 4'b0010; dec_illegal = 1'b0;
        dec_a = rs_q; dec_b = {16'd0, imm}; dec_rd = instr_q[20:16];
      end
      6'b001111: begin
        dec_aluc = 4'b0110; dec_illegal = 1'b0;
        dec_a = {16'd0, imm}; dec_b = 32'd0; dec_rd = instr_q[20:16];
      end
      default: ;
    endcase
  end

  // Datapath: latch request, register decode, capture ALU, count accepted records
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      instr_q    <= 32'd0;
      rs_q       <= 32'd0;
      rt_q       <= 32'd0;
      alu_a_q    <= 32'd0;
      alu_b_q    <= 32'd0;
      aluc_q     <= 4'b0000;
      result_q   <= 32'd0;
      z_q        <= 1'b0;
      rd_q       <= 5'd0;
      wreg_q     <= 1'b0;
      illegal_q  <= 1'b0;
      op_count_q <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            instr_q <= instr;
            rs_q    <= rs_val;
            rt_q    <= rt_val;
          end
        end
        DECODE: begin
          alu_a_q   <= dec_a;
          alu_b_q   <= dec_b;
          aluc_q    <= dec_aluc;
          rd_q      <= dec_rd;
          illegal_q <= dec_illegal;
          wreg_q    <= !dec_illegal && (dec_rd != 5'd0);
        end
        EXEC: begin
          // Illegal records report zero regardless of what the ALU shows
          result_q <= illegal_q ? 32'd0 : alu_s;
          z_q      <= illegal_q ? 1'b0  : alu_z;
        end
        DONE: begin
          if (out_ready) op_count_q <= op_count_q + 32'd1;
        end
        default: ;
      endcase
    end
  end

  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_aluc    = aluc_q;
  assign out_result  = result_q;
  assign out_z       = z_q;
  assign out_rd      = rd_q;
  assign out_wreg    = wreg_q;
  assign out_illegal = illegal_q;
  assign op_count    = op_count_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed-vector bench for alu_seq with a behavioural ALU attached.
module tb_alu_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr, rs_val, rt_val;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_aluc;
  logic [31:0] alu_s;
  logic        alu_z;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_z;
  logic [4:0]  out_rd;
  logic        out_wreg;
  logic        out_illegal;
  logic [31:0] op_count;

  int n_vec  = 0;
  int n_fail = 0;
  logic [31:0] exp_ops = 32'd0;

  always #5 clock = ~clock;

  alu_seq dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs_val(rs_val), .rt_val(rt_val),
    .alu_a(alu_a), .alu_b(alu_b), .alu_aluc(alu_aluc),
    .alu_s(alu_s), .alu_z(alu_z),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_z(out_z), .out_rd(out_rd),
    .out_wreg(out_wreg), .out_illegal(out_illegal), .op_count(op_count)
  );

  // Behavioural ALU consuming the aluc encoding
  always_comb begin
    alu_s = 32'd0;
    case (alu_aluc)
      4'b0000: alu_s = alu_a + alu_b;
      4'b0100: alu_s = alu_a - alu_b;
      4'b0001: alu_s = alu_a & alu_b;
      4'b0101: alu_s = alu_a | alu_b;
      4'b0010: alu_s = alu_a ^ alu_b;
      4'b1011: alu_s = 32'($countones(alu_a ^ alu_b));
      4'b0011: alu_s = alu_b << alu_a[4:0];
      4'b0111: alu_s = alu_b >> alu_a[4:0];
      4'b1111: alu_s = $signed(alu_b) >>> alu_a[4:0];
      4'b0110: alu_s = {alu_a[15:0], 16'd0};
      default: alu_s = 32'd0;
    endcase
    alu_z = (alu_s == 32'd0);
  end

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic [3:0]  exp_aluc;
    logic [31:0] exp_result;
    logic        exp_z;
    logic [4:0]  exp_rd;
    logic        exp_wreg;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One full transaction with per-edge timing checks
  task automatic do_vec(input int idx, input vec_t v);
    @(negedge clock);
    instr = v.instr; rs_val = v.rs; rt_val = v.rt;
    in_valid = 1'b1; out_ready = 1'b0;
    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    @(posedge clock); #1;                    // edge N: accepted
    in_valid = 1'b0;
    chk("in_ready_decode", {31'd0, in_ready}, 32'd0);
    @(posedge clock); #1;                    // edge N+1: ALU drive valid
    chk("alu_aluc", {28'd0, alu_aluc}, {28'd0, v.exp_aluc});
    chk("alu_a", alu_a, v.exp_a);
    chk("alu_b", alu_b, v.exp_b);
    chk("out_valid_exec", {31'd0, out_valid}, 32'd0);
    @(posedge clock); #1;                    // edge N+2: record presented
    chk("out_valid_done", {31'd0, out_valid}, 32'd1);
    chk("out_result", out_result, v.exp_result);
    chk("out_z", {31'd0, out_z}, {31'd0, v.exp_z});
    if (!v.exp_ill) chk("out_rd", {27'd0, out_rd}, {27'd0, v.exp_rd});
    chk("out_wreg", {31'd0, out_wreg}, {31'd0, v.exp_wreg});
    chk("out_illegal", {31'd0, out_illegal}, {31'd0, v.exp_ill});
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    exp_ops = exp_ops + 32'd1;
    chk("op_count", op_count, exp_ops);
    chk("out_valid_after", {31'd0, out_valid}, 32'd0);
    $display("vec %0d instr=0x%08h result=0x%08h z=%0b rd=%0d wreg=%0b ill=%0b",
             idx, v.instr, out_result, out_z, out_rd, out_wreg, out_illegal);
  endtask

  logic [31:0] hold_result;

  initial begin
    //          instr         rs            rt            exp_a         exp_b         aluc     result        z     rd    wreg  ill
    vecs[0]  = '{32'h00221820, 32'd5,       32'd7,        32'd5,        32'd7,        4'b0000, 32'd12,       1'b0, 5'd3, 1'b1, 1'b0}; // add
    vecs[1]  = '{32'h00222022, 32'h1234,    32'h1234,     32'h1234,     32'h1234,     4'b0100, 32'd0,        1'b1, 5'd4, 1'b1, 1'b0}; // sub
    vecs[2]  = '{32'h00053103, 32'd0,       32'h80000000, 32'd4,        32'h80000000, 4'b1111, 32'hF8000000, 1'b0, 5'd6, 1'b1, 1'b0}; // sra
    vecs[3]  = '{32'h3C051234, 32'hDEADBEEF,32'd0,        32'h1234,     32'd0,        4'b0110, 32'h12340000, 1'b0, 5'd5, 1'b1, 1'b0}; // lui
    vecs[4]  = '{32'h2022FFFF, 32'd1,       32'd0,        32'd1,        32'hFFFFFFFF, 4'b0000, 32'd0,        1'b1, 5'd2, 1'b1, 1'b0}; // addi
    vecs[5]  = '{32'h3023FFFF, 32'hABCD1234,32'd0,        32'hABCD1234, 32'h0000FFFF, 4'b0001, 32'h00001234, 1'b0, 5'd3, 1'b1, 1'b0}; // andi
    vecs[6]  = '{32'h00223828, 32'hFF,      32'h0F,       32'hFF,       32'h0F,       4'b1011, 32'd4,        1'b0, 5'd7, 1'b1, 1'b0}; // hd
    vecs[7]  = '{32'hFC000000, 32'h55,      32'hAA,       32'd0,        32'd0,        4'b0000, 32'd0,        1'b0, 5'd0, 1'b0, 1'b1}; // illegal op
    vecs[8]  = '{32'h00220020, 32'd3,       32'd4,        32'd3,        32'd4,        4'b0000, 32'd7,        1'b0, 5'd0, 1'b0, 1'b0}; // add rd=0
    vecs[9]  = '{32'h00222825, 32'hF0F0,    32'h0F0F,     32'hF0F0,     32'h0F0F,     4'b0101, 32'hFFFF,     1'b0, 5'd5, 1'b1, 1'b0}; // or
    vecs[10] = '{32'h00053200, 32'd9,       32'd1,        32'd8,        32'd1,        4'b0011, 32'h100,      1'b0, 5'd6, 1'b1, 1'b0}; // sll
    vecs[11] = '{32'h00053102, 32'd9,       32'h80000000, 32'd4,        32'h80000000, 4'b0111, 32'h08000000, 1'b0, 5'd6, 1'b1, 1'b0}; // srl
    vecs[12] = '{32'h382200FF, 32'hFF00,    32'd0,        32'hFF00,     32'hFF,       4'b0010, 32'hFFFF,     1'b0, 5'd2, 1'b1, 1'b0}; // xori
    vecs[13] = '{32'h3422F000, 32'h0F00,    32'd0,        32'h0F00,     32'hF000,     4'b0101, 32'hFF00,     1'b0, 5'd2, 1'b1, 1'b0}; // ori
    vecs[14] = '{32'h00222023, 32'd0,       32'd1,        32'd0,        32'd1,        4'b0100, 32'hFFFFFFFF, 1'b0, 5'd4, 1'b1, 1'b0}; // subu wrap
    vecs[15] = '{32'h0022203F, 32'h55,      32'hAA,       32'd0,        32'd0,        4'b0000, 32'd0,        1'b0, 5'd0, 1'b0, 1'b1}; // illegal funct

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    instr = 32'd0; rs_val = 32'd0; rt_val = 32'd0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_alu_aluc", {28'd0, alu_aluc}, 32'd0);
    chk("rst_op_count", op_count, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) do_vec(i, vecs[i]);

    // Backpressure: hold DONE for 10 cycles with a competing request on the input
    @(negedge clock);
    instr = 32'h00221820; rs_val = 32'd20; rt_val = 32'd22; in_valid = 1'b1;
    @(posedge clock); #1;
    instr = 32'h00222022; rs_val = 32'd50; rt_val = 32'd8;   // next request, held pending
    repeat (2) @(posedge clock);
    #1;
    hold_result = 32'd42;
    for (int c = 0; c < 10; c++) begin
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_result", out_result, hold_result);
      chk("bp_rd", {27'd0, out_rd}, 32'd3);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_op_count", op_count, exp_ops);
      @(posedge clock); #1;
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    exp_ops = exp_ops + 32'd1;
    chk("bp_release_count", op_count, exp_ops);
    chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clock); #1;                    // pending sub accepted here
    in_valid = 1'b0;
    chk("bp_next_accepted", {31'd0, in_ready}, 32'd0);
    repeat (2) @(posedge clock);
    #1;
    chk("bp_next_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_next_result", out_result, 32'd42);
    chk("bp_next_rd", {27'd0, out_rd}, 32'd4);
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    exp_ops = exp_ops + 32'd1;
    chk("bp_next_count", op_count, exp_ops);
    $display("backpressure sequence op_count=%0d", op_count);

    // Reset during EXEC aborts the instruction
    @(negedge clock);
    instr = 32'h00221820; rs_val = 32'd1; rt_val = 32'd2; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(posedge clock); #1;                    // now in EXEC
    reset = 1'b1;
    #1;
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_alu_a", alu_a, 32'd0);
    chk("mid_rst_alu_b", alu_b, 32'd0);
    chk("mid_rst_op_count", op_count, 32'd0);
    chk("mid_rst_rd", {27'd0, out_rd}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    exp_ops = 32'd0;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clock); #1;
      chk("post_rst_no_record", {31'd0, out_valid}, 32'd0);
    end
    out_ready = 1'b0;
    chk("post_rst_op_count", op_count, 32'd0);
    $display("reset-abort sequence op_count=%0d", op_count);

    do_vec(0, vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
